line_fifo_sched: RTL

- Controller for the two parallel line FIFOs (row FIFO, column FIFO) that sit between the parser and the solver.
- During load it muxes parser writes into the FIFO the parser selects. During solve it alternates row and column passes, gates solver reads and write-backs, and tracks occupancy.
- It detects convergence, stall and overflow, and tells the top-level FSM when solving is finished.

---
 rtl/nonogram_pkg.sv | 16 +
 rtl/line_fifo_track.sv | 65 ++++++
 rtl/line_fifo_sched.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/nonogram_pkg.sv
// Shared types and default sizing for the nonogram line-FIFO scheduler.
package nonogram_pkg;

    localparam int unsigned DEF_WORD_W     = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 1024;
    localparam int unsigned DEF_MAX_PASSES = 64;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_ROW_PASS,
        ST_COL_PASS,
        ST_DONE,
        ST_ERROR
    } sched_state_t;

endpackage

// File: rtl/line_fifo_track.sv
// Per-FIFO bookkeeping: accept gating, occupancy, remaining-in-pass and overflow detect.
module line_fifo_track
    import nonogram_pkg::*;
#(
    parameter int unsigned CNT_W = $clog2(DEF_FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             wr_req,
    input  logic             rd_req,
    input  logic             full,
    input  logic             empty,
    output logic             wr_acc,
    output logic             rd_acc,
    output logic             ovf,
    output logic [CNT_W-1:0] remaining,
    output logic [CNT_W-1:0] rem_next
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    // A write into a full FIFO is dropped and flagged instead of strobed.
    always_comb begin
        wr_acc = wr_req & ~full;
        rd_acc = rd_req & ~empty;
        ovf    = wr_req & full;
    end

    // Remaining is latched from the post-update occupancy so a same-cycle write counts.
    always_comb begin
        cnt_d = cnt_q;
        rem_d = rem_q;
        if (clr) begin
            cnt_d = '0;
        end else if (wr_acc && !rd_acc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (clr) begin
            rem_d = '0;
        end else if (load) begin
            rem_d = cnt_d;
        end else if (rd_acc && (rem_q != '0)) begin
            rem_d = rem_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            rem_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
        end
    end

    assign remaining = rem_q;
    assign rem_next  = rem_d;

endmodule

// File: rtl/line_fifo_sched.sv
// Scheduler for the row/column line FIFOs: load muxing, alternating solve passes,
// convergence/stall/overflow detection and FIFO reset sequencing.
module line_fifo_sched
    import nonogram_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned WORD_W     = DEF_WORD_W,
    parameter int unsigned MAX_PASSES = DEF_MAX_PASSES
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              parse_write,
    input  logic [WORD_W-1:0]                 parse_line,
    input  logic                              parse_row,
    input  logic                              parsed,
    input  logic                              solve_next_r,
    input  logic                              solve_next_c,
    input  logic                              solve_write_r,
    input  logic                              solve_write_c,
    input  logic [WORD_W-1:0]                 solve_line_r,
    input  logic [WORD_W-1:0]                 solve_line_c,
    input  logic                              line_busy,
    input  logic                              progress,
    input  logic                              solved,
    input  logic                              clear,
    input  logic                              fifo_full_r,
    input  logic                              fifo_empty_r,
    input  logic                              fifo_full_c,
    input  logic                              fifo_empty_c,
    output logic [WORD_W-1:0]                 fifo_in_r,
    output logic [WORD_W-1:0]                 fifo_in_c,
    output logic                              fifo_write_r,
    output logic                              fifo_write_c,
    output logic                              fifo_read_r,
    output logic                              fifo_read_c,
    output logic                              fifo_srst,
    output logic                              grant_r,
    output logic                              grant_c,
    output logic                              done,
    output logic                              stalled,
    output logic                              overflow,
    output logic [$clog2(MAX_PASSES+1)-1:0]   pass_count
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PASS_W = $clog2(MAX_PASSES + 1);

    sched_state_t state_q, state_d;
    logic              grant_r_q, grant_r_d, grant_c_q, grant_c_d;
    logic              done_q, done_d, stalled_q, stalled_d;
    logic              overflow_q, overflow_d, srst_q, srst_d;
    logic              seen_q, seen_d, round_prog;
    logic [PASS_W-1:0] pass_q, pass_d;

    logic              wr_req_r, wr_req_c, rd_req_r, rd_req_c;
    logic              ovf_r, ovf_c, load_r, load_c, clr_cnt;
    logic [CNT_W-1:0]  rem_r, rem_c, rem_next_r, rem_next_c;

    // Strobe requests and write data follow the current state with no added latency.
    always_comb begin
        wr_req_r  = 1'b0;
        wr_req_c  = 1'b0;
        rd_req_r  = 1'b0;
        rd_req_c  = 1'b0;
        fifo_in_r = '0;
        fifo_in_c = '0;
        if (!rst) begin
            unique case (state_q)
                ST_LOAD: begin
                    wr_req_r  = parse_write & parse_row;
                    wr_req_c  = parse_write & ~parse_row;
                    fifo_in_r = parse_line;
                    fifo_in_c = parse_line;
                end
                ST_ROW_PASS: begin
                    wr_req_r  = solve_write_r;
                    rd_req_r  = solve_next_r & grant_r_q;
                    fifo_in_r = solve_line_r;
                end
                ST_COL_PASS: begin
                    wr_req_c  = solve_write_c;
                    rd_req_c  = solve_next_c & grant_c_q;
                    fifo_in_c = solve_line_c;
                end
                default: ;
            endcase
        end
    end

    line_fifo_track #(.CNT_W(CNT_W)) u_row (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_cnt),
        .load      (load_r),
        .wr_req    (wr_req_r),
        .rd_req    (rd_req_r),
        .full      (fifo_full_r),
        .empty     (fifo_empty_r),
        .wr_acc    (fifo_write_r),
        .rd_acc    (fifo_read_r),
        .ovf       (ovf_r),
        .remaining (rem_r),
        .rem_next  (rem_next_r)
    );

    line_fifo_track #(.CNT_W(CNT_W)) u_col (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_cnt),
        .load      (load_c),
        .wr_req    (wr_req_c),
        .rd_req    (rd_req_c),
        .full      (fifo_full_c),
        .empty     (fifo_empty_c),
        .wr_acc    (fifo_write_c),
        .rd_acc    (fifo_read_c),
        .ovf       (ovf_c),
        .remaining (rem_c),
        .rem_next  (rem_next_c)
    );

    // Next state: overflow beats solved, solved beats a pass end.
    always_comb begin
        state_d    = state_q;
        stalled_d  = stalled_q;
        overflow_d = overflow_q;
        pass_d     = pass_q;
        seen_d     = seen_q;
        round_prog = seen_q | progress;
        unique case (state_q)
            ST_LOAD: begin
                if (ovf_r || ovf_c) begin
                    state_d    = ST_ERROR;
                    overflow_d = 1'b1;
                end else if (parsed) begin
                    state_d = ST_ROW_PASS;
                    pass_d  = '0;
                    seen_d  = 1'b0;
                end
            end
            ST_ROW_PASS: begin
                seen_d = round_prog;
                if (ovf_r) begin
                    state_d    = ST_ERROR;
                    overflow_d = 1'b1;
                end else if (solved) begin
                    state_d = ST_DONE;
                end else if ((rem_r == '0) && !line_busy) begin
                    state_d = ST_COL_PASS;
                end
            end
            ST_COL_PASS: begin
                seen_d = round_prog;
                if (ovf_c) begin
                    state_d    = ST_ERROR;
                    overflow_d = 1'b1;
                end else if (solved) begin
                    state_d = ST_DONE;
                end else if ((rem_c == '0) && !line_busy) begin
                    if (!round_prog) begin
                        state_d   = ST_DONE;
                        stalled_d = 1'b1;
                    end else if (pass_q == PASS_W'(MAX_PASSES - 1)) begin
                        state_d   = ST_DONE;
                        stalled_d = 1'b1;
                        pass_d    = PASS_W'(MAX_PASSES);
                    end else begin
                        state_d = ST_ROW_PASS;
                        pass_d  = pass_q + PASS_W'(1);
                        seen_d  = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                if (clear) begin
                    state_d   = ST_LOAD;
                    stalled_d = 1'b0;
                    pass_d    = '0;
                end
            end
            default: ;
        endcase
    end

    // Pass-entry latches and counter clears; counters follow the FIFO reset.
    always_comb begin
        load_r  = (state_d == ST_ROW_PASS) && (state_q != ST_ROW_PASS);
        load_c  = (state_d == ST_COL_PASS) && (state_q != ST_COL_PASS);
        clr_cnt = (state_d != state_q) &&
                  ((state_d == ST_DONE) || (state_d == ST_ERROR) || (state_d == ST_LOAD));
    end

    always_comb begin
        grant_r_d = (state_d == ST_ROW_PASS) && (rem_next_r != '0);
        grant_c_d = (state_d == ST_COL_PASS) && (rem_next_c != '0);
        done_d    = (state_d == ST_DONE) || (state_d == ST_ERROR);
        srst_d    = (state_d == ST_ERROR) || ((state_d == ST_DONE) && (state_q != ST_DONE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            grant_r_q  <= 1'b0;
            grant_c_q  <= 1'b0;
            done_q     <= 1'b0;
            stalled_q  <= 1'b0;
            overflow_q <= 1'b0;
            srst_q     <= 1'b1;
            seen_q     <= 1'b0;
            pass_q     <= '0;
        end else begin
            state_q    <= state_d;
            grant_r_q  <= grant_r_d;
            grant_c_q  <= grant_c_d;
            done_q     <= done_d;
            stalled_q  <= stalled_d;
            overflow_q <= overflow_d;
            srst_q     <= srst_d;
            seen_q     <= seen_d;
            pass_q     <= pass_d;
        end
    end

    assign grant_r    = grant_r_q;
    assign grant_c    = grant_c_q;
    assign done       = done_q;
    assign stalled    = stalled_q;
    assign overflow   = overflow_q;
    assign fifo_srst  = srst_q;
    assign pass_count = pass_q;

endmodule
